// File: rtl/cordic_mul_pkg.sv
// Shared widths, latency and in-flight tag type for the shared CORDIC multiplier scheduler.
// The tag ID field is sized for the largest supported requester count (8).
package cordic_mul_pkg;

   localparam int A_W      = 16;
   localparam int B_W      = 12;
   localparam int P_W      = A_W + B_W;
   localparam int LAT      = 4;
   localparam int TAG_ID_W = 3;

   function automatic int id_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   typedef struct packed {
      logic                v;
      logic [TAG_ID_W-1:0] id;
   } mul_tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last winner (ptr_i).
// The grant index is valid whenever any request is present; the grant vector is gated by en_i.
module cordic_rr_arbiter
   import cordic_mul_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  gnt_idx_o
);

   logic found;
   int   idx;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr_i) + k) % N_REQ;
         if (!found && req_i[idx]) begin
            found     = 1'b1;
            gnt_idx_o = ID_W'(idx);
            gnt_o[idx] = en_i;
         end
      end
   end

endmodule

// File: rtl/cordic_mul_rr_scheduler.sv
// Shares one pipelined signed x unsigned multiplier among N_REQ requesters.
// The tag pipe runs in lockstep with the multiplier; a stalled response freezes both via mul_ce.
module cordic_mul_rr_scheduler
   import cordic_mul_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = id_w(N_REQ)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [N_REQ-1:0]     req_valid_i,
   output logic [N_REQ-1:0]     req_ready_o,
   input  logic [N_REQ*A_W-1:0] req_a_i,
   input  logic [N_REQ*B_W-1:0] req_b_i,
   output logic               mul_ce_o,
   output logic [A_W-1:0]     mul_din0_o,
   output logic [B_W-1:0]     mul_din1_o,
   input  logic [P_W-1:0]     mul_dout_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [ID_W-1:0]    rsp_id_o,
   output logic [P_W-1:0]     rsp_p_o,
   output logic               busy_o
);

   localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

   mul_tag_t         tag_q [LAT];
   mul_tag_t         tag_d [LAT];
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [A_W-1:0]   din0_q, din0_d;
   logic [B_W-1:0]   din1_q, din1_d;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_idx;
   logic             mul_ce;
   logic             hs;

   assign mul_ce = !(tag_q[LAT-1].v && !rsp_ready_i);
   assign hs     = |gnt;

   cordic_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_i     (req_valid_i),
      .ptr_i     (rr_ptr_q),
      .en_i      (mul_ce),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   always_comb begin
      tag_d    = tag_q;
      rr_ptr_d = rr_ptr_q;
      din0_d   = din0_q;
      din1_d   = din1_q;
      if (mul_ce) begin
         tag_d[0].v  = hs;
         tag_d[0].id = hs ? TAG_ID_W'(gnt_idx) : '0;
         for (int k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];
         if (hs) begin
            din0_d   = req_a_i[int'(gnt_idx)*A_W +: A_W];
            din1_d   = req_b_i[int'(gnt_idx)*B_W +: B_W];
            rr_ptr_d = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
         rr_ptr_q <= PTR_RST;
         din0_q   <= '0;
         din1_q   <= '0;
      end else begin
         tag_q    <= tag_d;
         rr_ptr_q <= rr_ptr_d;
         din0_q   <= din0_d;
         din1_q   <= din1_d;
      end
   end

   // Stale multiplier output is harmless: rsp_valid comes only from the tag pipe.
   always_comb begin
      busy_o = 1'b0;
      for (int k = 0; k < LAT; k++) busy_o = busy_o | tag_q[k].v;
   end

   assign req_ready_o = gnt;
   assign mul_ce_o    = mul_ce;
   assign mul_din0_o  = din0_q;
   assign mul_din1_o  = din1_q;
   assign rsp_valid_o = tag_q[LAT-1].v;
   assign rsp_id_o    = ID_W'(tag_q[LAT-1].id);
   assign rsp_p_o     = mul_dout_i;

endmodule

// File: tb/tb_cordic_mul_rr_scheduler.sv
// Self-checking bench: behavioural multiplier, queue-based response model, vector table,
// directed corner sequences and a randomized traffic phase.
module tb_cordic_mul_rr_scheduler;
   import cordic_mul_pkg::*;

   localparam int N  = 4;
   localparam int IW = id_w(N);

   logic               clk = 1'b0;
   logic               reset;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*A_W-1:0]   req_a;
   logic [N*B_W-1:0]   req_b;
   logic               mul_ce;
   logic [A_W-1:0]     mul_din0;
   logic [B_W-1:0]     mul_din1;
   logic [P_W-1:0]     mul_dout;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IW-1:0]      rsp_id;
   logic [P_W-1:0]     rsp_p;
   logic               busy;

   always #5 clk = ~clk;

   cordic_mul_rr_scheduler #(.N_REQ(N)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .mul_ce_o    (mul_ce),
      .mul_din0_o  (mul_din0),
      .mul_din1_o  (mul_din1),
      .mul_dout_i  (mul_dout),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_id_o    (rsp_id),
      .rsp_p_o     (rsp_p),
      .busy_o      (busy)
   );

   // Behavioural multiplier: three ce-gated stages after the operand register.
   logic signed [P_W-1:0] s1, s2, s3;
   always @(posedge clk) begin
      if (mul_ce) begin
         s1 <= $signed(mul_din0) * $signed({1'b0, mul_din1});
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign mul_dout = s3;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: ordered queue of accepted jobs, each counting ce edges until visible.
   typedef struct {
      int     id;
      longint p;
      int     cnt;
   } ent_t;
   ent_t mq[$];
   int   m_ptr;

   logic [N-1:0]   r_valid;
   logic [A_W-1:0] r_a [N];
   logic [B_W-1:0] r_b [N];
   logic           rdy;

   function automatic longint prod(input int i);
      return longint'($signed(r_a[i])) * longint'(r_b[i]);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ptr = N - 1;
   endtask

   // One clock cycle: drive at negedge, compare, then advance the model past the posedge.
   // want: -2 no grant check, -1 expect no grant, else expected winner.
   task automatic step(input int want);
      bit           ev, ece;
      int           w, dw;
      logic [N-1:0] er;
      @(negedge clk);
      req_valid = r_valid;
      for (int i = 0; i < N; i++) begin
         req_a[i*A_W +: A_W] = r_a[i];
         req_b[i*B_W +: B_W] = r_b[i];
      end
      rsp_ready = rdy;
      #1;
      ev  = (mq.size() > 0) && (mq[0].cnt == 0);
      ece = !(ev && !rdy);
      w   = -1;
      if (ece)
         for (int k = 1; k <= N; k++)
            if (w < 0 && r_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("mul_ce", mul_ce, ece);
      chk("rsp_valid", rsp_valid, ev);
      chk("busy", busy, mq.size() > 0);
      if (ev) begin
         chk("rsp_id", rsp_id, mq[0].id);
         chk("rsp_p", longint'($signed(rsp_p)), mq[0].p);
      end
      if (want != -2) begin
         dw = -1;
         for (int i = 0; i < N; i++) if (req_ready[i]) dw = i;
         chk("grant", dw, want);
      end
      @(posedge clk);
      if (ece) begin
         if (ev && rdy) void'(mq.pop_front());
         foreach (mq[j]) mq[j].cnt--;
         if (w >= 0) begin
            mq.push_back('{id: w, p: prod(w), cnt: LAT - 1});
            m_ptr      = w;
            r_valid[w] = 1'b0;
         end
      end
   endtask

   typedef struct {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      longint         p;
   } vec_t;
   vec_t vt[6];

   initial begin
      int             edges;
      logic [IW-1:0]  hold_id;
      logic [P_W-1:0] hold_p;

      vt[0] = '{a: 16'h8000, b: 12'hFFF, p: -134184960};
      vt[1] = '{a: 16'h7FFF, b: 12'hFFF, p: 134180865};
      vt[2] = '{a: 16'hFFFF, b: 12'h000, p: 0};
      vt[3] = '{a: 16'd1234, b: 12'd1,   p: 1234};
      vt[4] = '{a: 16'hFFFF, b: 12'hFFF, p: -4095};
      vt[5] = '{a: 16'd300,  b: 12'd2048, p: 614400};

      reset     = 1'b1;
      r_valid   = '0;
      rdy       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         r_a[i] = '0;
         r_b[i] = '0;
      end
      model_reset();
      #12;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_din0", mul_din0, 0);
      chk("rst_din1", mul_din1, 0);
      @(negedge clk);
      reset = 1'b0;

      // Single request from req0: latency, id and product.
      r_valid[0] = 1'b1; r_a[0] = 16'hFFFD; r_b[0] = 12'd100;
      step(0);
      edges = 1;
      #1;
      while (!rsp_valid && edges < 10) begin
         step(-2);
         edges++;
         #1;
      end
      chk("latency_edges", edges, 4);
      chk("first_id", rsp_id, 0);
      chk("first_p", longint'($signed(rsp_p)), -300);
      step(-2);
      #1;
      chk("busy_after_drain", busy, 0);

      // Vector table through req0.
      foreach (vt[t]) begin
         r_valid[0] = 1'b1; r_a[0] = vt[t].a; r_b[0] = vt[t].b;
         step(0);
         repeat (3) step(-1);
         #1;
         chk("vec_valid", rsp_valid, 1);
         chk("vec_p", longint'($signed(rsp_p)), vt[t].p);
         step(-2);
      end

      // Reset with three products in flight and the first one already presented.
      for (int i = 0; i < 3; i++) begin
         r_valid[0] = 1'b1; r_a[0] = A_W'(100 + i); r_b[0] = B_W'(7 + i);
         step(0);
      end
      rdy = 1'b0;
      step(-1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_busy", busy, 0);
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rdy   = 1'b1;
      repeat (6) step(-1);

      // All requesters continuously valid: strict 0,1,2,3 rotation, one response per cycle.
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < N; i++)
            if (!r_valid[i]) begin
               r_valid[i] = 1'b1; r_a[i] = A_W'(1000 * i + k); r_b[i] = B_W'(10 + i + k);
            end
         step(k % N);
      end

      // Backpressure with the pipe full: no grants, response frozen.
      rdy = 1'b0;
      #1;
      hold_id = rsp_id;
      hold_p  = rsp_p;
      for (int k = 0; k < 3; k++) begin
         step(-1);
         chk("stall_id_stable", rsp_id, hold_id);
         chk("stall_p_stable", rsp_p, hold_p);
      end
      rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++)
            if (!r_valid[i]) begin
               r_valid[i] = 1'b1; r_a[i] = A_W'(-77 * (i + k)); r_b[i] = B_W'(4000 - i - k);
            end
         step(-2);
      end
      r_valid = '0;
      repeat (6) step(-1);

      // Fairness: last winner req0, req0+req3 held -> 3 then 0; req1 joins -> 1.
      r_valid[0] = 1'b1; r_a[0] = 16'd5; r_b[0] = 12'd5;
      step(0);
      r_valid[0] = 1'b1; r_valid[3] = 1'b1; r_a[3] = 16'd9; r_b[3] = 12'd9;
      step(3);
      r_valid[3] = 1'b1;
      step(0);
      r_valid[0] = 1'b1; r_valid[1] = 1'b1; r_a[1] = 16'd11; r_b[1] = 12'd3;
      step(1);
      r_valid = '0;
      repeat (6) step(-2);

      // Randomized traffic with random backpressure.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++)
            if (!r_valid[i] && $urandom_range(0, 99) < 40) begin
               r_valid[i] = 1'b1;
               r_a[i] = A_W'($urandom);
               r_b[i] = B_W'($urandom);
            end
         rdy = ($urandom_range(0, 99) < 70);
         step(-2);
      end
      r_valid = '0;
      rdy     = 1'b1;
      repeat (8) step(-2);
      #1;
      chk("final_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
